// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state encoding and constants for the PLL reset/lock sequencer
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_GATE_WAIT = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pll_lock_filt.sv
// rtl/pll_lock_filt.sv - pll_lock synchroniser plus saturating debounce counter
module pll_lock_filt
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_FILT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic clr,
    output logic lock_s,
    output logic lock_q
);

    localparam int CW = $clog2(LOCK_FILT) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          filt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Any low sample restarts qualification; the count parks at LOCK_FILT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
        end else if (clr || !lock_s) begin
            filt_cnt <= '0;
        end else if (filt_cnt != CW'(LOCK_FILT)) begin
            filt_cnt <= filt_cnt + CW'(1);
        end
    end

    assign lock_q = (filt_cnt == CW'(LOCK_FILT));

endmodule

// File: rtl/pll_rst_seq_ctrl.sv
// rtl/pll_rst_seq_ctrl.sv - PLL reset pulse, lock qualification and clkout0 gating; PLL_CTRL_AUTO_RECOVER_EN selects lock-loss recovery
module pll_rst_seq_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_FILT    = 1024,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int GATE_DLY     = 16,
    parameter int MAX_RETRY    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       sw_restart,
    output logic       pll_rst,
    output logic       clkout0_gate,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int GW = $clog2(GATE_DLY) + 1;

    pll_state_e    state_q, nxt;
    logic [2:0]    retry_q, retry_nxt;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gate_cnt;
    logic          lock_s, lock_q, stay;

    pll_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .clr      (nxt == ST_RST),
        .lock_s   (lock_s),
        .lock_q   (lock_q)
    );

    always_comb begin
        nxt       = state_q;
        retry_nxt = retry_q;
        case (state_q)
            ST_RST: if (rst_cnt == RW'(RST_CYCLES - 1)) nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    nxt = ST_GATE_WAIT;
                end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_nxt = (retry_q >= 3'(MAX_RETRY)) ? retry_q : retry_q + 3'd1;
                    nxt       = (retry_nxt == 3'(MAX_RETRY)) ? ST_FAIL : ST_RST;
                end
            end
            ST_GATE_WAIT: begin
                if (!lock_s)                                nxt = ST_RST;
                else if (gate_cnt == GW'(GATE_DLY - 1))     nxt = ST_RUN;
            end
            ST_RUN: begin
`ifdef PLL_CTRL_AUTO_RECOVER_EN
                if (!lock_s) nxt = ST_RST;
`else
                if (!lock_s) nxt = ST_FAIL;
`endif
            end
            ST_FAIL: nxt = ST_FAIL;
            default: nxt = ST_RST;
        endcase
        if (sw_restart) begin
            nxt       = ST_RST;
            retry_nxt = '0;
        end
    end

    // Counters run only while the state is held; a restart re-arms them even inside RST.
    assign stay = (nxt == state_q) && !sw_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt  <= '0;
            to_cnt   <= '0;
            gate_cnt <= '0;
        end else begin
            rst_cnt  <= (stay && state_q == ST_RST)       ? rst_cnt + RW'(1)  : '0;
            to_cnt   <= (stay && state_q == ST_WAIT_LOCK) ? to_cnt + TW'(1)   : '0;
            gate_cnt <= (stay && state_q == ST_GATE_WAIT) ? gate_cnt + GW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            retry_q      <= '0;
            pll_rst      <= 1'b1;
            clkout0_gate <= 1'b0;
            pll_ready    <= 1'b0;
            pll_fail     <= 1'b0;
        end else begin
            state_q      <= nxt;
            retry_q      <= retry_nxt;
            pll_rst      <= (nxt == ST_RST) || (nxt == ST_FAIL);
            clkout0_gate <= (nxt == ST_RUN);
            pll_ready    <= (nxt == ST_RUN);
            pll_fail     <= (nxt == ST_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_rst_seq_ctrl.sv
// tb/tb_pll_rst_seq_ctrl.sv - directed self-checking bench for pll_rst_seq_ctrl
module tb_pll_rst_seq_ctrl;
    import pll_ctrl_pkg::*;

    localparam int R = 8;
    localparam int F = 32;
    localparam int T = 200;
    localparam int G = 4;
    localparam int M = 4;

    logic       clk, rst_n, pll_lock, sw_restart;
    logic       pll_rst, clkout0_gate, pll_ready, pll_fail;
    logic [2:0] retry_cnt, state;
    int         n_checks, n_fail;

    pll_rst_seq_ctrl #(
        .RST_CYCLES(R), .LOCK_FILT(F), .LOCK_TIMEOUT(T), .GATE_DLY(G), .MAX_RETRY(M)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_restart(sw_restart),
        .pll_rst(pll_rst), .clkout0_gate(clkout0_gate), .pll_ready(pll_ready),
        .pll_fail(pll_fail), .retry_cnt(retry_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_restart();
        sw_restart = 1'b1;
        tick(1);
        sw_restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_lock = 1'b0; sw_restart = 1'b0;
        tick(3);
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        n_checks++; if (clkout0_gate !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %b want 0", clkout0_gate); end
        n_checks++; if (pll_ready !== 1'b0 || pll_fail !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fail: got %b%b want 00", pll_ready, pll_fail); end
        n_checks++; if (retry_cnt !== 3'd0 || state !== ST_RST) begin n_fail++; $display("FAIL reset_retry_state: got %0d/%0d want 0/0", retry_cnt, state); end
    endtask

    task automatic test_cold_start();
        rst_n = 1'b1;
        tick(R - 1);
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL cold_rst_held: got %b want 1", pll_rst); end
        tick(1);
        n_checks++; if (pll_rst !== 1'b0 || state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL cold_rst_fall: got rst=%b st=%0d want 0/1", pll_rst, state); end
    endtask

    task automatic test_lock_seq();
        tick(20);
        pll_lock = 1'b1;
        tick(2 + F + G);
        n_checks++; if (clkout0_gate !== 1'b0 || state !== ST_GATE_WAIT) begin n_fail++; $display("FAIL lock_gate_early: got gate=%b st=%0d want 0/2", clkout0_gate, state); end
        tick(1);
        n_checks++; if (clkout0_gate !== 1'b1 || pll_ready !== 1'b1) begin n_fail++; $display("FAIL lock_gate_rise: got gate=%b rdy=%b want 1/1", clkout0_gate, pll_ready); end
        n_checks++; if (state !== ST_RUN || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL lock_run: got st=%0d retry=%0d want 3/0", state, retry_cnt); end
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        tick(2);
        n_checks++; if (clkout0_gate !== 1'b1) begin n_fail++; $display("FAIL loss_gate_hold: got %b want 1", clkout0_gate); end
        tick(1);
        n_checks++; if (clkout0_gate !== 1'b0 || pll_ready !== 1'b0) begin n_fail++; $display("FAIL loss_gate_fall: got gate=%b rdy=%b want 0/0", clkout0_gate, pll_ready); end
`ifdef PLL_CTRL_AUTO_RECOVER_EN
        n_checks++; if (state !== ST_RST || pll_rst !== 1'b1 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL loss_recover: got st=%0d rst=%b retry=%0d want 0/1/0", state, pll_rst, retry_cnt); end
        tick(R - 1);
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_rst_width: got %b want 1", pll_rst); end
        tick(1);
        n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL loss_rst_end: got %b want 0", pll_rst); end
`else
        n_checks++; if (state !== ST_FAIL || pll_fail !== 1'b1 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_to_fail: got st=%0d fail=%b rst=%b want 4/1/1", state, pll_fail, pll_rst); end
        tick(10);
        n_checks++; if (state !== ST_FAIL) begin n_fail++; $display("FAIL loss_fail_hold: got %0d want 4", state); end
`endif
    endtask

    task automatic test_sw_restart();
        pulse_restart();
        n_checks++; if (state !== ST_RST || pll_fail !== 1'b0 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL restart_state: got st=%0d fail=%b retry=%0d want 0/0/0", state, pll_fail, retry_cnt); end
        tick(R - 1);
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL restart_rst_held: got %b want 1", pll_rst); end
        tick(1);
        n_checks++; if (pll_rst !== 1'b0 || state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL restart_rst_fall: got rst=%b st=%0d want 0/1", pll_rst, state); end
    endtask

    task automatic test_glitch();
        tick(20);
        pll_lock = 1'b1;
        tick(20);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2 + F);
        n_checks++; if (state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL glitch_still_wait: got %0d want 1", state); end
        tick(1);
        n_checks++; if (state !== ST_GATE_WAIT) begin n_fail++; $display("FAIL glitch_gate_wait: got %0d want 2", state); end
        tick(G - 1);
        n_checks++; if (clkout0_gate !== 1'b0) begin n_fail++; $display("FAIL glitch_gate_early: got %b want 0", clkout0_gate); end
        tick(1);
        n_checks++; if (clkout0_gate !== 1'b1) begin n_fail++; $display("FAIL glitch_gate_rise: got %b want 1", clkout0_gate); end
        pulse_restart();
        n_checks++; if (clkout0_gate !== 1'b0 || state !== ST_RST || pll_ready !== 1'b0) begin n_fail++; $display("FAIL run_restart: got gate=%b st=%0d rdy=%b want 0/0/0", clkout0_gate, state, pll_ready); end
        pll_lock = 1'b0;
    endtask

    task automatic test_rst_n_gate_wait();
        tick(R);
        pll_lock = 1'b1;
        tick(3 + F);
        n_checks++; if (state !== ST_GATE_WAIT) begin n_fail++; $display("FAIL rstn_reach_gw: got %0d want 2", state); end
        tick(1);
        rst_n = 1'b0;
        #1;
        n_checks++; if (pll_rst !== 1'b1 || state !== ST_RST || clkout0_gate !== 1'b0 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL rstn_async: got rst=%b st=%0d gate=%b retry=%0d want 1/0/0/0", pll_rst, state, clkout0_gate, retry_cnt); end
        tick(2);
        rst_n = 1'b1;
        tick(R - 1);
        n_checks++; if (pll_rst !== 1'b1 || state !== ST_RST) begin n_fail++; $display("FAIL rstn_restart_held: got rst=%b st=%0d want 1/0", pll_rst, state); end
        tick(1);
        n_checks++; if (pll_rst !== 1'b0 || state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL rstn_restart_fall: got rst=%b st=%0d want 0/1", pll_rst, state); end
    endtask

    task automatic test_fail_retry();
        pll_lock = 1'b0;
        pulse_restart();
        tick(R + T - 1);
        n_checks++; if (state !== ST_WAIT_LOCK || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL retry_pre_timeout: got st=%0d retry=%0d want 1/0", state, retry_cnt); end
        tick(1);
        n_checks++; if (state !== ST_RST || retry_cnt !== 3'd1 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL retry_first: got st=%0d retry=%0d rst=%b want 0/1/1", state, retry_cnt, pll_rst); end
        tick(3 * (R + T) - 1);
        n_checks++; if (state !== ST_WAIT_LOCK || retry_cnt !== 3'd3 || pll_fail !== 1'b0) begin n_fail++; $display("FAIL retry_third: got st=%0d retry=%0d fail=%b want 1/3/0", state, retry_cnt, pll_fail); end
        tick(1);
        n_checks++; if (state !== ST_FAIL || retry_cnt !== 3'd4 || pll_fail !== 1'b1 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL retry_to_fail: got st=%0d retry=%0d fail=%b rst=%b want 4/4/1/1", state, retry_cnt, pll_fail, pll_rst); end
        tick(50);
        n_checks++; if (state !== ST_FAIL || retry_cnt !== 3'd4) begin n_fail++; $display("FAIL retry_fail_hold: got st=%0d retry=%0d want 4/4", state, retry_cnt); end
    endtask

    task automatic test_restart_vs_timeout();
        pulse_restart();
        n_checks++; if (retry_cnt !== 3'd0 || pll_fail !== 1'b0 || state !== ST_RST) begin n_fail++; $display("FAIL fail_restart: got retry=%0d fail=%b st=%0d want 0/0/0", retry_cnt, pll_fail, state); end
        tick(4 * (R + T) - 1);
        n_checks++; if (state !== ST_WAIT_LOCK || retry_cnt !== 3'd3) begin n_fail++; $display("FAIL race_setup: got st=%0d retry=%0d want 1/3", state, retry_cnt); end
        pulse_restart();
        n_checks++; if (state !== ST_RST || retry_cnt !== 3'd0 || pll_fail !== 1'b0) begin n_fail++; $display("FAIL race_restart_wins: got st=%0d retry=%0d fail=%b want 0/0/0", state, retry_cnt, pll_fail); end
        tick(R);
        n_checks++; if (state !== ST_WAIT_LOCK || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL race_new_seq: got st=%0d retry=%0d want 1/0", state, retry_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_cold_start();
        test_lock_seq();
        test_lock_loss();
        test_sw_restart();
        test_glitch();
        test_rst_n_gate_wait();
        test_fail_retry();
        test_restart_vs_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq_ctrl.md
# pll_rst_seq_ctrl

Reset/lock sequencer for the DDR3 clocking PLL (50 MHz in, gated 400 MHz clkout0). Sits beside the PLL in the DDR3 clock subsystem and is clocked from the same free-running 50 MHz reference. Drives the PLL reset with a defined pulse width and qualifies the lock with a debounce filter. Opens clkout0's output gate only after a stable lock, with bounded retry on lock timeout and recovery on lock loss.

## Interface
- RST_CYCLES, 64: `pll_rst` assertion width per attempt, clk cycles (≥2)
- LOCK_FILT, 1024: consecutive synchronised-high `pll_lock` cycles required to qualify lock (≥1)
- LOCK_TIMEOUT, 100000: max cycles in WAIT_LOCK before the attempt fails (> LOCK_FILT)
- GATE_DLY, 16: cycles between qualified lock and `clkout0_gate` assertion (≥1)
- MAX_RETRY, 4: failed attempts before entering FAIL (1..7)
- clk  in  1  free-running 50 MHz reference, same net as PLL clkin1
- rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous to clk
- sw_restart  in  1  single-cycle pulse; restarts sequencing from any state
- pll_rst  out  1  PLL reset, active-high
- clkout0_gate  out  1  clkout0 output enable to the PLL
- pll_ready  out  1  high only in RUN
- pll_fail  out  1  high only in FAIL
- retry_cnt  out  3  failed attempts since the last restart
- state  out  3  current FSM state encoding, for debug

## Operation
- Under reset: `pll_rst`=1, `clkout0_gate`=0, `pll_ready`=0, `pll_fail`=0, `retry_cnt`=0, state=RST.
- `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. The filter counter clears on any `lock_s`=0 and saturates at LOCK_FILT; `lock_q` is high when the counter equals LOCK_FILT.
- The state machine has five states:
  - RST: `pll_rst`=1; count RST_CYCLES, then go to WAIT_LOCK. Entry clears the filter counter.
  - WAIT_LOCK: `pll_rst`=0; the timeout counter runs.
    - `lock_q`=1 → GATE_WAIT.
    - Timeout reached → `retry_cnt`+1. If the new value equals MAX_RETRY → FAIL, else → RST.
  - GATE_WAIT: count GATE_DLY. If `lock_s` drops → RST, with no retry increment. Otherwise → RUN.
  - RUN: `clkout0_gate`=1, `pll_ready`=1. On lock loss (`lock_s`=0), behaviour is set by the Configuration macro below.
  - FAIL: `pll_rst`=1 and `pll_fail`=1. Held until `sw_restart`.
- `sw_restart` has top priority in every state. It forces RST, clears `retry_cnt` and all counters, and drops the gate the next cycle.
- `retry_cnt` saturates at MAX_RETRY and never wraps.
- All counters are sized with $clog2 of their parameter plus 1. A counter resets on every state entry.

## Timing
- All outputs are registered and change one cycle after the state transition.
- Cold start, PLL locking immediately: `pll_rst` falls RST_CYCLES cycles after `rst_n` deasserts.
- From `pll_lock` rising to `clkout0_gate` rising takes 2 + LOCK_FILT + GATE_DLY + 1 cycles.
- Lock loss in RUN: `clkout0_gate` falls 3 cycles after `pll_lock` falls (2 synchroniser + 1 register).
- If `sw_restart` and a timeout occur in the same cycle, the restart wins and `retry_cnt` becomes 0.
- Asserting `rst_n` mid-sequence immediately forces the reset values.

## Configuration
- PLL_CTRL_AUTO_RECOVER_EN defined: lock loss in RUN → RST, `retry_cnt` unchanged. The ensuing WAIT_LOCK timeouts count toward MAX_RETRY.
- Not defined: lock loss in RUN → FAIL directly, and only `sw_restart` recovers.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the 3-bit state encoding: RST=0, WAIT_LOCK=1, GATE_WAIT=2, RUN=3, FAIL=4;
  - the synchroniser depth constant (2).
- Sub-module `pll_lock_filt` holds the synchroniser and saturating filter counter. Its outputs are `lock_s` and `lock_q`, and it has a clear input driven on RST entry.

## Test plan
- Default parameters, `pll_lock` rises 200 cycles after `pll_rst` falls → `clkout0_gate` rises 200+2+1024+16+1 cycles after `pll_rst` falls; `pll_ready`=1; `retry_cnt`=0.
- `pll_lock` glitches low for 1 cycle at filter count 500 → filter restarts; gate is delayed by a further ~502 cycles.
- `pll_lock` held 0 → four RST/WAIT_LOCK cycles, then `pll_fail`=1, `retry_cnt`=4, `pll_rst`=1; then `sw_restart` → `retry_cnt`=0, new sequence.
- RUN then `pll_lock` falls → gate=0 three cycles later. With the macro, state goes to RST and `pll_rst` pulses for 64 cycles; without it, state goes to FAIL.
- `rst_n` pulsed low during GATE_WAIT → all outputs at reset values immediately, and the sequence restarts at RST.
- `sw_restart` in the same cycle as the 4th timeout → state RST, `retry_cnt`=0, `pll_fail` stays 0.
